// File: rtl/gc_frame_seq_pkg.sv
// Shared constants and types for the Gray-stage frame sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package gc_frame_seq_pkg;

  // Decoder default configuration: 1023-beat codewords, 10-bit beat index.
  localparam int GC_CW_LEN = 1023;
  localparam int GC_CNT_W  = 10;

  // Sticky error flag bit positions in out_err.
  localparam int ERR_OVR  = 0;  // start flag seen while a frame is running
  localparam int ERR_ORPH = 1;  // beat seen outside a frame without start

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/gc_frame_seq_if.sv
// Beat input / frame-marker output bundle between a beat source and the sequencer.
// Latency: n/a (wires only).
// Backpressure: none; beats are always accepted when in_ctr_en is high.
interface gc_frame_seq_if #(
  parameter int CNT_W = 10
);
  logic             in_ctr_init;
  logic             in_ctr_en;
  logic             in_ctr_start;
  logic             out_vld;
  logic [CNT_W-1:0] out_idx;
  logic             out_first;
  logic             out_last;
  logic             out_busy;
  logic             out_gc_en;
  logic             out_gc_init;
  logic [1:0]       out_err;

  // Beat source side.
  modport master (
    output in_ctr_init, in_ctr_en, in_ctr_start,
    input  out_vld, out_idx, out_first, out_last, out_busy,
           out_gc_en, out_gc_init, out_err
  );

  // Sequencer side.
  modport slave (
    input  in_ctr_init, in_ctr_en, in_ctr_start,
    output out_vld, out_idx, out_first, out_last, out_busy,
           out_gc_en, out_gc_init, out_err
  );
endinterface

// File: rtl/gc_frame_seq_frame_beat_cnt.sv
// Mod-CW_LEN beat counter with sync clear, load-1 and enable; tc flags CW_LEN-1.
// Latency: cnt updates on the clock edge after clr/load1/en.
// Backpressure: none; holds when no control is asserted.
module frame_beat_cnt #(
  parameter int CW_LEN = 1023,
  parameter int CNT_W  = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             load1,
  input  logic             en,
  output logic [CNT_W-1:0] cnt,
  output logic             tc
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Terminal count is CW_LEN-1, not the natural 2^CNT_W rollover.
  assign tc  = (cnt_q == CNT_W'(CW_LEN - 1));
  assign cnt = cnt_q;

  // Next count: clear beats load-1 beats increment.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (load1) begin
      cnt_d = CNT_W'(1);
    end else if (en) begin
      cnt_d = tc ? '0 : cnt_q + CNT_W'(1);
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/gc_frame_seq.sv
// Frame sequencer: beat indexing, first/last flags, one Gray advance per codeword, framing errors.
// Latency: 1 cycle from accepted beat to out_vld/idx/first/last/gc_en; busy visible 1 cycle after transition.
// Backpressure: none; every beat with in_ctr_en is accepted or dropped (orphan) the same cycle.
module gc_frame_seq
  import gc_frame_seq_pkg::*;
#(
  parameter int CW_LEN = GC_CW_LEN,
  parameter int CNT_W  = GC_CNT_W
) (
  input  logic           clk,
  input  logic           in_ctr_Srst,
  gc_frame_seq_if.slave  bus
);

  state_e           state_q, state_d;
  logic             vld_q, vld_d;
  logic [CNT_W-1:0] idx_q, idx_d;
  logic             first_q, first_d;
  logic             last_q, last_d;
  logic             busy_q, busy_d;
  logic             gc_en_q, gc_en_d;
  logic             gc_init_q, gc_init_d;
  logic [1:0]       err_q, err_d;

  logic             cnt_clr, cnt_load1, cnt_inc;
  logic [CNT_W-1:0] cnt;
  logic             cnt_tc;

  frame_beat_cnt #(
    .CW_LEN (CW_LEN),
    .CNT_W  (CNT_W)
  ) u_cnt (
    .clk   (clk),
    .rst   (in_ctr_Srst),
    .clr   (cnt_clr),
    .load1 (cnt_load1),
    .en    (cnt_inc),
    .cnt   (cnt),
    .tc    (cnt_tc)
  );

  // Next state, counter controls and the registered output stage; init outranks beats.
  always_comb begin
    state_d   = state_q;
    vld_d     = 1'b0;
    idx_d     = idx_q;
    first_d   = 1'b0;
    last_d    = 1'b0;
    gc_en_d   = 1'b0;
    gc_init_d = 1'b0;
    err_d     = err_q;
    cnt_clr   = 1'b0;
    cnt_load1 = 1'b0;
    cnt_inc   = 1'b0;

    if (bus.in_ctr_init) begin
      state_d   = ST_IDLE;
      cnt_clr   = 1'b1;
      err_d     = '0;
      gc_init_d = 1'b1;
    end else if (bus.in_ctr_en) begin
      if (bus.in_ctr_start) begin
        // A start in RUN abandons the running frame without an advance pulse.
        if (state_q == ST_RUN) err_d[ERR_OVR] = 1'b1;
        state_d   = ST_RUN;
        cnt_load1 = 1'b1;
        vld_d     = 1'b1;
        idx_d     = '0;
        first_d   = 1'b1;
      end else if (state_q == ST_IDLE) begin
        err_d[ERR_ORPH] = 1'b1;
      end else begin
        cnt_inc = 1'b1;
        vld_d   = 1'b1;
        idx_d   = cnt;
        if (cnt_tc) begin
          last_d  = 1'b1;
          gc_en_d = 1'b1;
          state_d = ST_IDLE;
        end
      end
    end

    busy_d = (state_d == ST_RUN);
  end

  // Output and state registers with synchronous reset to all-zero.
  always_ff @(posedge clk) begin
    if (in_ctr_Srst) begin
      state_q   <= ST_IDLE;
      vld_q     <= 1'b0;
      idx_q     <= '0;
      first_q   <= 1'b0;
      last_q    <= 1'b0;
      busy_q    <= 1'b0;
      gc_en_q   <= 1'b0;
      gc_init_q <= 1'b0;
      err_q     <= '0;
    end else begin
      state_q   <= state_d;
      vld_q     <= vld_d;
      idx_q     <= idx_d;
      first_q   <= first_d;
      last_q    <= last_d;
      busy_q    <= busy_d;
      gc_en_q   <= gc_en_d;
      gc_init_q <= gc_init_d;
      err_q     <= err_d;
    end
  end

  assign bus.out_vld     = vld_q;
  assign bus.out_idx     = idx_q;
  assign bus.out_first   = first_q;
  assign bus.out_last    = last_q;
  assign bus.out_busy    = busy_q;
  assign bus.out_gc_en   = gc_en_q;
  assign bus.out_gc_init = gc_init_q;
  assign bus.out_err     = err_q;

endmodule

// File: tb/tb_gc_frame_seq.sv
// Randomized + directed bench for gc_frame_seq with a frame-level reference model and scoreboard.
// Latency: expects every output one cycle after the inputs that cause it.
// Backpressure: none exercised; the DUT has no stall path.
module tb_gc_frame_seq;

  localparam int CW_LEN = 4;
  localparam int CNT_W  = 3;

  typedef struct {
    logic             vld;
    logic [CNT_W-1:0] idx;
    logic             chk_idx;
    logic             first;
    logic             last;
    logic             busy;
    logic             gc_en;
    logic             gc_init;
    logic [1:0]       err;
  } exp_t;

  logic clk;
  logic in_ctr_Srst;

  gc_frame_seq_if #(.CNT_W(CNT_W)) bus ();

  gc_frame_seq #(
    .CW_LEN (CW_LEN),
    .CNT_W  (CNT_W)
  ) dut (
    .clk         (clk),
    .in_ctr_Srst (in_ctr_Srst),
    .bus         (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;

  // Reference model state: whether a frame is open, next beat position, sticky errors.
  bit   m_run  = 1'b0;
  int   m_pos  = 0;
  bit [1:0] m_err = 2'b00;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, got, want);
    end
  endtask

  // One cycle of stimulus; the model computes what the DUT must show next cycle.
  task automatic drive(input bit rst, input bit init, input bit en, input bit start);
    exp_t e;
    @(negedge clk);
    in_ctr_Srst      = rst;
    bus.in_ctr_init  = init;
    bus.in_ctr_en    = en;
    bus.in_ctr_start = start;
    e.vld = 0; e.idx = '0; e.chk_idx = 0; e.first = 0; e.last = 0;
    e.gc_en = 0; e.gc_init = 0;
    if (rst) begin
      m_run = 0; m_pos = 0; m_err = 2'b00;
      e.chk_idx = 1;
    end else if (init) begin
      m_run = 0; m_pos = 0; m_err = 2'b00;
      e.gc_init = 1;
    end else if (en && start) begin
      if (m_run) m_err[0] = 1'b1;
      m_run = 1; m_pos = 1;
      e.vld = 1; e.idx = '0; e.chk_idx = 1; e.first = 1;
    end else if (en) begin
      if (!m_run) begin
        m_err[1] = 1'b1;
      end else begin
        e.vld = 1; e.idx = CNT_W'(m_pos); e.chk_idx = 1;
        if (m_pos == CW_LEN - 1) begin
          e.last = 1; e.gc_en = 1;
          m_run = 0; m_pos = 0;
        end else begin
          m_pos++;
        end
      end
    end
    e.busy = m_run;
    e.err  = m_err;
    exp_q.push_back(e);
  endtask

  // Monitor: one expected record per cycle, compared just after the edge.
  always @(posedge clk) begin
    exp_t e;
    #1;
    cyc++;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("out_vld",     32'(bus.out_vld),     32'(e.vld));
      if (e.chk_idx) check("out_idx", 32'(bus.out_idx), 32'(e.idx));
      check("out_first",   32'(bus.out_first),   32'(e.first));
      check("out_last",    32'(bus.out_last),    32'(e.last));
      check("out_busy",    32'(bus.out_busy),    32'(e.busy));
      check("out_gc_en",   32'(bus.out_gc_en),   32'(e.gc_en));
      check("out_gc_init", 32'(bus.out_gc_init), 32'(e.gc_init));
      check("out_err",     32'(bus.out_err),     32'(e.err));
    end
  end

  initial begin
    in_ctr_Srst      = 1'b1;
    bus.in_ctr_init  = 1'b0;
    bus.in_ctr_en    = 1'b0;
    bus.in_ctr_start = 1'b0;

    // Reset, then a single frame followed by idle.
    drive(1, 0, 0, 0);
    drive(1, 0, 1, 1);
    drive(0, 0, 1, 1);
    for (int i = 0; i < 3; i++) drive(0, 0, 1, 0);
    drive(0, 0, 0, 0);
    drive(0, 0, 0, 0);

    // Back-to-back frames, starts on beats 0 and 4.
    for (int i = 0; i < 8; i++) drive(0, 0, 1, (i % 4) == 0);
    drive(0, 0, 0, 0);

    // Gapped beats across one frame.
    for (int i = 0; i < 8; i++) drive(0, 0, (i % 2) == 0, i == 0);
    drive(0, 0, 0, 0);

    // Overrun: restart at beat 2, then complete the new frame.
    drive(0, 0, 1, 1);
    drive(0, 0, 1, 0);
    drive(0, 0, 1, 1);
    for (int i = 0; i < 3; i++) drive(0, 0, 1, 0);
    drive(0, 0, 0, 0);

    // Orphan beats in IDLE, then init clears errors.
    drive(0, 0, 1, 0);
    drive(0, 0, 1, 0);
    drive(0, 0, 0, 0);
    drive(0, 1, 0, 0);
    drive(0, 0, 0, 0);

    // Mid-frame init with a beat on the same cycle.
    drive(0, 0, 1, 1);
    drive(0, 1, 1, 0);
    drive(0, 0, 1, 0);

    // Srst at idx 2, then a clean frame.
    drive(0, 0, 1, 1);
    drive(0, 0, 1, 0);
    drive(0, 0, 1, 0);
    drive(1, 0, 1, 0);
    drive(0, 0, 1, 1);
    for (int i = 0; i < 3; i++) drive(0, 0, 1, 0);
    drive(0, 0, 0, 0);

    // Randomized traffic, mostly well-formed frames with occasional faults.
    for (int i = 0; i < 600; i++) begin
      bit r_rst, r_init, r_en, r_start;
      r_rst   = ($urandom_range(0, 99) < 2);
      r_init  = ($urandom_range(0, 99) < 4);
      r_en    = ($urandom_range(0, 99) < 75);
      r_start = m_run ? ($urandom_range(0, 99) < 8) : ($urandom_range(0, 99) < 80);
      drive(r_rst, r_init, r_en, r_start);
    end
    drive(0, 0, 0, 0);

    repeat (3) @(negedge clk);
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain got=%0d pending want=0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
